fpu_arbiter: RTL

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Shares one restartable FPU between two requesters with round-robin arbitration; response pulses WAIT_CYCLES+3 cycles after accept.
// Backpressure: ready is held low outside IDLE, nothing is queued, and a requester simply keeps valid high until it is granted.
module fpu_arbiter #(
    parameter int WAIT_CYCLES = 40
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_reset,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       last_grant;
    logic       gid;
    logic       accept;

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b1;
        fpu_reset  = reset;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // On a tie, the requester that did not win last time gets the grant.
                if (req0_valid && req1_valid) begin
                    req0_ready = last_grant;
                    req1_ready = !last_grant;
                end else begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid;
                end
                if (req0_ready || req1_ready) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                fpu_reset = 1'b0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = !gid;
                rsp1_valid = gid;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept = req0_ready || req1_ready;

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            fpu_op_a   <= 32'd0;
            fpu_op_b   <= 32'd0;
            rsp_data   <= 32'd0;
            rsp_status <= 4'd0;
        end else begin
            if (state == S_LAUNCH) begin
                wait_cnt <= 8'd0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (accept) begin
                last_grant <= req1_ready;
                gid        <= req1_ready;
                fpu_op_a   <= req1_ready ? req1_a : req0_a;
                fpu_op_b   <= req1_ready ? req1_b : req0_b;
            end
            // A status of 0000 means the FPU produced nothing; it is passed on as-is.
            if (state == S_CAPTURE) begin
                rsp_data   <= fpu_data;
                rsp_status <= fpu_status;
            end
        end
    end

endmodule
